uart_rx_ctrl: RTL and testbench

UART receive framing controller that sits directly downstream of the rx_bps baud-tick generator and closes the loop with it. It synchronises the serial rxd line and detects the start-bit falling edge, then drives count_signal to rx_bps. It samples each bit on bps_clk_half and delivers the received byte with a one-cycle valid strobe plus error flags to the video-transfer command logic. Framing is 8N1 by default; optional parity is selectable by parameter.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_ctrl_if.sv | 35 +++
 rtl/rx_sync_edge.sv | 44 ++++
 rtl/uart_rx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t  : receive FSM encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   CLK_HZ, BPS : system clock and default baud rate the rx_bps divider is built for
//   parity_of() : reduction parity over the low nbits of a word, optionally inverted
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int unsigned CLK_HZ = 200_000_000;
  localparam int unsigned BPS    = 115_200;

  // Parity of the low nbits of data; odd = 1 inverts the result so that the
  // return value is always the parity bit the transmitter should have sent.
  function automatic logic parity_of(input logic [7:0] data, input int nbits,
                                     input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: groups the rx_bps loop signals and the received-word
// outputs of uart_rx_ctrl.
//   bps_clk_half / bps_clk_total : pulses from rx_bps (bit centre / bit end)
//   count_signal                 : run request back to rx_bps
//   rx_data, rx_valid            : received word and its strobe
//   frame_err, parity_err        : error strobes, rx_busy: frame in progress
//   modport master : the receive controller
//   modport slave  : the environment (rx_bps + command logic)
//
// Handshake: rx_valid is a push-only strobe with no ready. It is high for
// exactly one clk cycle and rx_data is valid in that cycle and stays stable
// until the next rx_valid; the consumer must capture it or lose the word.
// frame_err and parity_err follow the same one-cycle push rule.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 bps_clk_half;
  logic                 bps_clk_total;
  logic                 count_signal;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_busy;

  modport master (
    input  bps_clk_half, bps_clk_total,
    output count_signal, rx_data, rx_valid, frame_err, parity_err, rx_busy
  );

  modport slave (
    output bps_clk_half, bps_clk_total,
    input  count_signal, rx_data, rx_valid, frame_err, parity_err, rx_busy
  );
endinterface

// File: rtl/rx_sync_edge.sv
// rx_sync_edge: brings the asynchronous rxd line into the clk domain and
// flags its falling edges.
//   clk, rst   : clock, asynchronous active-low reset
//   rxd        : raw serial input (idle high)
//   rxd_s      : synchronised rxd (last stage of the synchroniser)
//   fall_pulse : one-cycle pulse, registered, one cycle after rxd_s falls
module rx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
    prev_d = sync_q[SYNC_STAGES-1];
    // previous rxd_s high, current rxd_s low
    fall_d = prev_q & ~sync_q[SYNC_STAGES-1];
  end

  // Reset to all ones so an idle-high line never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      fall_q <= fall_d;
    end
  end

  assign rxd_s      = sync_q[SYNC_STAGES-1];
  assign fall_pulse = fall_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive framing controller working in a loop with the
// rx_bps baud-tick generator. Detects the start edge, requests bit timing
// via count_signal, samples every bit on bps_clk_half and delivers the word
// with a one-cycle strobe plus error flags.
//   clk, rst  : 200 MHz clock, asynchronous active-low reset
//   rxd       : raw serial input, idle high
//   bus       : uart_rx_ctrl_if master (bps pulses in, count_signal and
//               received-word outputs out)
//   dbg_state : current FSM state
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  uart_rx_ctrl_if.master bus,
  output rx_state_t      dbg_state
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic rxd_s;
  logic fall_pulse;

  rx_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rxd_s     (rxd_s),
    .fall_pulse(fall_pulse)
  );

  rx_state_t            state_q, state_d;
  logic                 count_q, count_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tot_seen_q, tot_seen_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;

  logic [7:0] data_ext;
  logic       par_ok;
  logic       good;

  always_comb begin
    data_ext                = '0;
    data_ext[DATA_BITS-1:0] = shift_q;
    par_ok = (PARITY_EN == 0) ||
             (par_bit_q == parity_of(data_ext, DATA_BITS, PARITY_ODD != 0));
    good   = rxd_s & par_ok;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_bit_d    = par_bit_q;
    tot_seen_d   = tot_seen_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_pulse) begin
          state_d = START;
          count_d = 1'b1;
        end
      end

      START: begin
        if (bus.bps_clk_half) begin
          if (rxd_s) begin
            // line went back high before the start-bit centre: a glitch
            state_d = IDLE;
            count_d = 1'b0;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end

      DATA: begin
        if (bus.bps_clk_half) begin
          // LSB first: each new bit enters at the top and walks down
          shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
            tot_seen_d = 1'b0;
          end
        end
      end

      PARITY: begin
        if (bus.bps_clk_half) begin
          par_bit_d  = rxd_s;
          state_d    = STOP;
          tot_seen_d = 1'b0;
        end
      end

      STOP: begin
        if (bus.bps_clk_half) begin
          state_d      = IDLE;
          count_d      = 1'b0;
          rx_valid_d   = good;
          frame_err_d  = ~rxd_s;
          parity_err_d = ~par_ok;
          if (good) rx_data_d = shift_q;
        end else if (bus.bps_clk_total) begin
          // STOP is entered at the previous bit's centre, so the end-of-bit
          // pulse of that bit is expected once. A second one means the
          // stop-bit centre was never seen: give up on the frame.
          if (tot_seen_q) begin
            state_d     = IDLE;
            count_d     = 1'b0;
            frame_err_d = 1'b1;
          end else begin
            tot_seen_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= 1'b0;
      busy_q       <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_bit_q    <= 1'b0;
      tot_seen_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_bit_q    <= par_bit_d;
      tot_seen_q   <= tot_seen_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.count_signal = count_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.parity_err   = parity_err_q;
  assign bus.rx_busy      = busy_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: two receivers, dut0 plain 8N1 and dut1 with even parity,
// each driven by a behavioural rx_bps model with a short 40-cycle bit period.
// Frames are built bit by bit from a byte; the expected outcome of every
// frame comes from the framing rules (stop bit level, XOR of the data bits)
// and is compared against strobes collected by a monitor.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int BIT      = 40;
  localparam int HALF_CNT = 19;
  localparam int TOT_CNT  = 39;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst;
  logic      rxd0, rxd1;
  rx_state_t dbg0, dbg1;

  uart_rx_ctrl_if #(.DATA_BITS(8)) if0 ();
  uart_rx_ctrl_if #(.DATA_BITS(8)) if1 ();

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .rxd(rxd0), .bus(if0), .dbg_state(dbg0)
  );
  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .bus(if1), .dbg_state(dbg1)
  );

  // ---------------- rx_bps models ----------------
  int cnt0, cnt1;
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt0 <= 0;
    else if (!if0.count_signal || cnt0 == TOT_CNT) cnt0 <= 0;
    else cnt0 <= cnt0 + 1;
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt1 <= 0;
    else if (!if1.count_signal || cnt1 == TOT_CNT) cnt1 <= 0;
    else cnt1 <= cnt1 + 1;
  end
  assign if0.bps_clk_half  = if0.count_signal && (cnt0 == HALF_CNT);
  assign if0.bps_clk_total = if0.count_signal && (cnt0 == TOT_CNT);
  assign if1.bps_clk_half  = if1.count_signal && (cnt1 == HALF_CNT);
  assign if1.bps_clk_total = if1.count_signal && (cnt1 == TOT_CNT);

  // ---------------- monitor ----------------
  int         v_cnt [2];
  int         f_cnt [2];
  int         p_cnt [2];
  logic [7:0] got0_q[$];
  logic [7:0] got1_q[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      v_cnt[i] = 0; f_cnt[i] = 0; p_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (if0.rx_valid)   begin v_cnt[0] = v_cnt[0] + 1; got0_q.push_back(if0.rx_data); end
    if (if1.rx_valid)   begin v_cnt[1] = v_cnt[1] + 1; got1_q.push_back(if1.rx_data); end
    if (if0.frame_err)  f_cnt[0] = f_cnt[0] + 1;
    if (if1.frame_err)  f_cnt[1] = f_cnt[1] + 1;
    if (if0.parity_err) p_cnt[0] = p_cnt[0] + 1;
    if (if1.parity_err) p_cnt[1] = p_cnt[1] + 1;
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         exp_fe, exp_pe;
  int         base_v, base_f, base_p;
  int         rd_ptr   [2];
  logic [7:0] last_good[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_of(input int idx);
    return (idx == 0) ? 32'(if0.rx_busy) : 32'(if1.rx_busy);
  endfunction
  function automatic logic [31:0] cs_of(input int idx);
    return (idx == 0) ? 32'(if0.count_signal) : 32'(if1.count_signal);
  endfunction
  function automatic logic [31:0] data_of(input int idx);
    return (idx == 0) ? 32'(if0.rx_data) : 32'(if1.rx_data);
  endfunction
  function automatic logic [31:0] state_of(input int idx);
    return (idx == 0) ? 32'(dbg0) : 32'(dbg1);
  endfunction
  function automatic logic [31:0] got_of(input int idx, input int k);
    if (idx == 0) return (k < got0_q.size()) ? 32'(got0_q[k]) : 32'hdead;
    return (k < got1_q.size()) ? 32'(got1_q[k]) : 32'hdead;
  endfunction

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic set_rxd(input int idx, input logic b);
    if (idx == 0) rxd0 = b;
    else          rxd1 = b;
  endtask

  task automatic drive_bit(input int idx, input logic b);
    set_rxd(idx, b);
    tick(BIT);
  endtask

  // Reference model: a frame is good when its stop bit is 1 and, with
  // parity enabled, the parity bit equals the even parity of the data byte.
  task automatic frame(input int idx, input logic [7:0] d, input bit par_en,
                       input logic pb, input logic sb, input int gap);
    logic par_ok;
    par_ok = !par_en || (pb == (^d));
    if (sb && par_ok) begin
      exp_q.push_back(d);
      last_good[idx] = d;
    end
    if (!sb)    exp_fe++;
    if (!par_ok) exp_pe++;

    drive_bit(idx, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(idx, d[i]);
    if (par_en) drive_bit(idx, pb);
    drive_bit(idx, sb);
    set_rxd(idx, 1'b1);
    tick(gap);
  endtask

  task automatic batch_begin(input int idx);
    exp_q.delete();
    exp_fe = 0;
    exp_pe = 0;
    base_v = v_cnt[idx];
    base_f = f_cnt[idx];
    base_p = p_cnt[idx];
  endtask

  task automatic batch_end(input int idx, input string tag);
    int w;
    int n;
    logic [7:0] e;
    w = 0;
    while (busy_of(idx) != 0 && w < 8 * BIT) begin
      @(posedge clk);
      w++;
    end
    tick(2);
    @(negedge clk);
    check($sformatf("%s_busy", tag), busy_of(idx), 32'd0);
    check($sformatf("%s_count_signal", tag), cs_of(idx), 32'd0);
    check($sformatf("%s_state", tag), state_of(idx), 32'(IDLE));
    check($sformatf("%s_n_valid", tag), 32'(v_cnt[idx] - base_v), 32'(exp_q.size()));
    check($sformatf("%s_n_frame_err", tag), 32'(f_cnt[idx] - base_f), 32'(exp_fe));
    check($sformatf("%s_n_parity_err", tag), 32'(p_cnt[idx] - base_p), 32'(exp_pe));
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_word%0d", tag, k), got_of(idx, rd_ptr[idx]), 32'(e));
      rd_ptr[idx]++;
    end
    rd_ptr[idx] = (idx == 0) ? got0_q.size() : got1_q.size();
    check($sformatf("%s_rx_data_held", tag), data_of(idx), 32'(last_good[idx]));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] d;
    logic       pb, sb;
    int         gap;

    rst  = 1'b0;
    rxd0 = 1'b1;
    rxd1 = 1'b1;
    rd_ptr[0] = 0; rd_ptr[1] = 0;
    last_good[0] = 8'h00; last_good[1] = 8'h00;
    tick(5);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_rx_data%0d", i), data_of(i), 32'd0);
      check($sformatf("reset_busy%0d", i), busy_of(i), 32'd0);
      check($sformatf("reset_count_signal%0d", i), cs_of(i), 32'd0);
      check($sformatf("reset_state%0d", i), state_of(i), 32'(IDLE));
    end
    check("reset_flags0", {29'd0, if0.rx_valid, if0.frame_err, if0.parity_err}, 32'd0);
    check("reset_flags1", {29'd0, if1.rx_valid, if1.frame_err, if1.parity_err}, 32'd0);
    @(posedge clk);
    rst = 1'b1;
    tick(10);

    // single 8N1 frame
    batch_begin(0);
    frame(0, 8'h55, 1'b0, 1'b0, 1'b1, BIT);
    batch_end(0, "f55");

    // back-to-back frames with no idle gap
    batch_begin(0);
    frame(0, 8'hA3, 1'b0, 1'b0, 1'b1, 0);
    frame(0, 8'h0F, 1'b0, 1'b0, 1'b1, BIT);
    batch_end(0, "b2b");

    // short low glitch on idle line: START entered, then aborted
    batch_begin(0);
    @(posedge clk);
    rxd0 = 1'b0;
    tick(6);
    @(negedge clk);
    check("glitch_busy_rise", busy_of(0), 32'd1);
    tick(2);
    rxd0 = 1'b1;
    tick(BIT);
    @(negedge clk);
    check("glitch_abort", busy_of(0), 32'd0);
    batch_end(0, "glitch");

    // stop bit driven low
    batch_begin(0);
    frame(0, 8'hC4, 1'b0, 1'b0, 1'b0, BIT);
    batch_end(0, "ferr");

    // even parity: 0x07 has three ones, so parity bit must be 1
    batch_begin(1);
    frame(1, 8'h07, 1'b1, 1'b0, 1'b1, BIT);
    batch_end(1, "perr");
    batch_begin(1);
    frame(1, 8'h07, 1'b1, 1'b1, 1'b1, BIT);
    batch_end(1, "pok");

    // reset in the middle of data bit 4 of 0xFF
    @(posedge clk);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    tick(BIT / 2);
    @(negedge clk);
    check("pre_reset_busy", busy_of(0), 32'd1);
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rx_data0", data_of(0), 32'd0);
    check("midrst_rx_data1", data_of(1), 32'd0);
    check("midrst_busy", busy_of(0), 32'd0);
    check("midrst_count_signal", cs_of(0), 32'd0);
    check("midrst_state", state_of(0), 32'(IDLE));
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    tick(3);
    rst = 1'b1;
    tick(BIT);
    batch_begin(0);
    frame(0, 8'h12, 1'b0, 1'b0, 1'b1, BIT);
    batch_end(0, "after_rst");

    // random 8N1 stream, mostly back-to-back, occasional bad stop bit
    batch_begin(0);
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 4) != 0);
      gap = sb ? ($urandom_range(0, 1) * $urandom_range(0, BIT)) : BIT;
      frame(0, d, 1'b0, 1'b0, sb, gap);
    end
    batch_end(0, "rnd_stream");

    // random parity frames, each checked on its own
    for (int i = 0; i < 10; i++) begin
      batch_begin(1);
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      frame(1, d, 1'b1, pb, sb, BIT);
      batch_end(1, $sformatf("rnd_par%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
